// File: rtl/epochtv1_vram_arb_pkg.sv
// Shared types for the TV-1 VRAM arbiter.
//   e_varb_st : arbiter FSM states
//   e_rid     : video requester id (also the VID_RID encoding)
//   grant_st  : maps a requester id onto its grant state
package epochtv1_vram_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CPU,
      ST_CPU_REC,
      ST_SPR,
      ST_BG
   } e_varb_st;

   typedef enum logic {
      RID_SPR = 1'b0,
      RID_BG  = 1'b1
   } e_rid;

   localparam int REC_CNT_W = 2;

   function automatic e_varb_st grant_st(input e_rid id);
      return (id == RID_BG) ? ST_BG : ST_SPR;
   endfunction

endpackage

// File: rtl/epochtv1_vram_arb_if.sv
// External VRAM pin bundle (port A = low byte, port B = high byte).
//   master : arbiter side, drives address, write data and write strobes
//   slave  : memory side, returns read data
interface epochtv1_vram_arb_if #(
   parameter int AW = 12
);
   logic [AW-1:0] vaa;
   logic [AW-1:0] vba;
   logic [7:0]    vad_wr;
   logic [7:0]    vbd_wr;
   logic [7:0]    vad_rd;
   logic [7:0]    vbd_rd;
   logic          nvawr;
   logic          nvbwr;

   modport master (
      output vaa, vba, vad_wr, vbd_wr, nvawr, nvbwr,
      input  vad_rd, vbd_rd
   );

   modport slave (
      input  vaa, vba, vad_wr, vbd_wr, nvawr, nvbwr,
      output vad_rd, vbd_rd
   );
endinterface

// File: rtl/epochtv1_vram_arb_rr2.sv
// Two-way picker between sprite and background fetch requests.
//   clk, rst_n     : clock, async active-low reset
//   ce_i           : clock enable, last-served flag only moves on CE
//   spr_req_i      : sprite request
//   bg_req_i       : background request
//   take_i         : the arbiter is issuing the picked grant this CE edge
//   gnt_vld_o      : some request is pending
//   gnt_id_o       : requester that would be granted
// RR_EN=1 alternates on contention, RR_EN=0 always prefers SPR.
module epochtv1_rr2
   import epochtv1_vram_arb_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce_i,
   input  logic spr_req_i,
   input  logic bg_req_i,
   input  logic take_i,
   output logic gnt_vld_o,
   output e_rid gnt_id_o
);

   e_rid last_q;

   always_comb begin
      gnt_vld_o = spr_req_i | bg_req_i;
      gnt_id_o  = RID_SPR;
      if (!spr_req_i)
         gnt_id_o = RID_BG;
      else if (bg_req_i && RR_EN && (last_q == RID_SPR))
         gnt_id_o = RID_BG;
   end

   // reset to BG so SPR wins the first contention
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_q <= RID_BG;
      else if (ce_i && take_i && gnt_vld_o)
         last_q <= gnt_id_o;
   end

endmodule

// File: rtl/epochtv1_vram_arb.sv
// TV-1 VRAM arbiter: CPU (absolute priority) vs sprite/background fetch.
//   clk, rst_n          : clock, async active-low reset
//   ce_i                : pixel clock enable, all state advances only on CE
//   cpu_sel/rd/wr/a/di  : CPU access into the VRAM window, cpu_a_i[0] = port B
//   cpu_do_o            : registered CPU read data
//   spr_/bg_req/a/ack   : video fetch requests (level, held until ack)
//   vid_rvalid/rid/rd_o : fetched word, one CE cycle after the grant
//   stall_o             : high while CPU owns or is recovering from VRAM
//   vram                : VRAM pins
//
// state   | meaning
// IDLE    | no owner, address parked
// CPU     | CPU owns VRAM, address/strobes follow CPU bus combinationally
// CPU_REC | dead time after CPU access, address parked, no strobes
// SPR     | one-cycle sprite fetch grant
// BG      | one-cycle background fetch grant
module epochtv1_vram_arb
   import epochtv1_vram_arb_pkg::*;
#(
   parameter int AW         = 12,
   parameter bit RR_EN      = 1'b1,
   parameter int REC_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ce_i,
   input  logic                cpu_sel_i,
   input  logic                cpu_rd_i,
   input  logic                cpu_wr_i,
   input  logic [AW:0]         cpu_a_i,
   input  logic [7:0]          cpu_di_i,
   output logic [7:0]          cpu_do_o,
   input  logic                spr_req_i,
   input  logic [AW-1:0]       spr_a_i,
   output logic                spr_ack_o,
   input  logic                bg_req_i,
   input  logic [AW-1:0]       bg_a_i,
   output logic                bg_ack_o,
   output logic                vid_rvalid_o,
   output logic                vid_rid_o,
   output logic [15:0]         vid_rd_o,
   output logic                stall_o,
   epochtv1_vram_arb_if.master vram
);

   localparam logic [REC_CNT_W-1:0] REC_LAST = REC_CNT_W'(REC_CYCLES - 1);

   e_varb_st             st_q, st_d, pick_st;
   logic [REC_CNT_W-1:0] rec_cnt_q;
   logic [AW-1:0]        addr_q;
   logic [7:0]           cpu_do_q;
   logic                 vid_rvalid_q;
   e_rid                 vid_rid_q;
   logic [15:0]          vid_rd_q;
   logic                 spr_ack_q, bg_ack_q, stall_q;

   logic cpu_req, cpu_wr_act, cpu_rd_act, take, gnt_vld;
   e_rid gnt_id;

   assign cpu_req    = cpu_sel_i & (cpu_rd_i | cpu_wr_i);
   // simultaneous RD and WR is treated as a write
   assign cpu_wr_act = cpu_req & cpu_wr_i;
   assign cpu_rd_act = cpu_req & cpu_rd_i & ~cpu_wr_i;

   epochtv1_rr2 #(.RR_EN(RR_EN)) u_rr2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce_i      (ce_i),
      .spr_req_i (spr_req_i),
      .bg_req_i  (bg_req_i),
      .take_i    (take),
      .gnt_vld_o (gnt_vld),
      .gnt_id_o  (gnt_id)
   );

   always_comb begin
      pick_st = ST_IDLE;
      if (cpu_req)
         pick_st = ST_CPU;
      else if (gnt_vld)
         pick_st = grant_st(gnt_id);

      st_d = st_q;
      case (st_q)
         ST_CPU:     st_d = cpu_req ? ST_CPU : ST_CPU_REC;
         ST_CPU_REC: begin
            if (cpu_req)
               st_d = ST_CPU;
            else if (rec_cnt_q == REC_LAST)
               st_d = pick_st;
         end
         default:    st_d = pick_st;
      endcase
   end

   assign take = (st_d == ST_SPR) || (st_d == ST_BG);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q         <= ST_IDLE;
         rec_cnt_q    <= '0;
         addr_q       <= '0;
         cpu_do_q     <= '0;
         vid_rvalid_q <= 1'b0;
         vid_rid_q    <= RID_SPR;
         vid_rd_q     <= '0;
         spr_ack_q    <= 1'b0;
         bg_ack_q     <= 1'b0;
         stall_q      <= 1'b0;
      end else if (ce_i) begin
         st_q      <= st_d;
         spr_ack_q <= (st_d == ST_SPR);
         bg_ack_q  <= (st_d == ST_BG);
         stall_q   <= (st_d == ST_CPU) || (st_d == ST_CPU_REC);

         // grant address is registered; CPU address is tracked so that
         // recovery keeps the bus parked on the last CPU word
         if (st_d == ST_SPR)
            addr_q <= spr_a_i;
         else if (st_d == ST_BG)
            addr_q <= bg_a_i;
         else if ((st_q == ST_CPU) && cpu_req)
            addr_q <= cpu_a_i[AW:1];

         if (st_q != ST_CPU_REC)
            rec_cnt_q <= '0;
         else if (rec_cnt_q != REC_LAST)
            rec_cnt_q <= rec_cnt_q + 1'b1;

         vid_rvalid_q <= (st_q == ST_SPR) || (st_q == ST_BG);
         if ((st_q == ST_SPR) || (st_q == ST_BG)) begin
            vid_rd_q  <= {vram.vbd_rd, vram.vad_rd};
            vid_rid_q <= (st_q == ST_BG) ? RID_BG : RID_SPR;
         end

         if ((st_q == ST_CPU) && cpu_rd_act)
            cpu_do_q <= cpu_a_i[0] ? vram.vbd_rd : vram.vad_rd;
      end
   end

   assign vram.vaa    = (st_q == ST_CPU) ? cpu_a_i[AW:1] : addr_q;
   assign vram.vba    = vram.vaa;
   assign vram.vad_wr = cpu_di_i;
   assign vram.vbd_wr = cpu_di_i;
   assign vram.nvawr  = ~((st_q == ST_CPU) & cpu_wr_act & ~cpu_a_i[0]);
   assign vram.nvbwr  = ~((st_q == ST_CPU) & cpu_wr_act &  cpu_a_i[0]);

   assign cpu_do_o     = cpu_do_q;
   assign spr_ack_o    = spr_ack_q;
   assign bg_ack_o     = bg_ack_q;
   assign vid_rvalid_o = vid_rvalid_q;
   assign vid_rid_o    = vid_rid_q;
   assign vid_rd_o     = vid_rd_q;
   assign stall_o      = stall_q;

endmodule
